fetch_unit: RTL and testbench

Parametrised instruction-fetch stage with a credit-limited request interface to a variable-latency instruction memory and a prefetch queue feeding decode through a valid/ready handshake. It holds the fetch PC, issues sequential word fetches, and redirects on branch/jump/return with squashing of in-flight responses. It replaces the single-cycle PC-plus-ROM fetch path in front of decode and supplies the PC+4 link value for JAL/JALR writeback.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_queue.sv | 52 +++++
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
package fetch_pkg;

  localparam int FETCH_DW = 32;
  localparam logic [FETCH_DW-1:0] RESET_PC_DEFAULT = 32'hBFC00000;

  // One prefetch-queue entry: the fetched word and the PC it came from.
  typedef struct packed {
    logic [FETCH_DW-1:0] instr;
    logic [FETCH_DW-1:0] pc;
  } fetch_entry_t;

  // Width of a counter that must reach `depth` inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO between the memory response path and decode.
// DEPTH is a power of two, so the read/write pointers wrap naturally.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = count_width(DEPTH)
) (
  input  logic          clk,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic [CW-1:0] count
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  // Storage write; no reset needed because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; flush empties the queue at once.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: credit-limited requests to a variable-latency
// memory, in-order responses into a prefetch queue, redirect with squash.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = FETCH_DW,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int                    FQ_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [DATA_WIDTH-1:0] dec_instr,
  output logic [DATA_WIDTH-1:0] dec_pc,
  output logic [DATA_WIDTH-1:0] dec_pc_plus4
);

  localparam int CW = count_width(FQ_DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
  } entry_t;

  logic [DATA_WIDTH-1:0] fetch_pc;
  logic [DATA_WIDTH-1:0] resp_pc;
  logic [DATA_WIDTH-1:0] redirect_aligned;
  logic [CW-1:0]         count;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         drop;
  logic [CW:0]           credit_used;
  logic                  fire;
  logic                  push;
  logic                  pop;
  logic                  drop_now;
  logic                  flush;
  entry_t                push_data;
  entry_t                head;

  assign redirect_aligned = redirect_pc & ~DATA_WIDTH'(3);

  // Queue slots plus in-flight fetches never exceed the queue depth, so
  // every non-squashed response is guaranteed a slot.
  assign credit_used = {1'b0, count} + {1'b0, outstanding};
  assign imem_req    = rst && !redirect_valid && (credit_used < (CW+1)'(FQ_DEPTH));
  assign imem_addr   = fetch_pc;
  assign fire        = imem_req && imem_gnt;

  assign drop_now  = imem_rvalid && (drop != '0);
  assign push      = imem_rvalid && (drop == '0) && !redirect_valid;
  assign push_data = '{instr: imem_rdata, pc: resp_pc};
  assign pop       = dec_valid && dec_ready;
  assign flush     = !rst || redirect_valid;

  fetch_queue #(
    .DEPTH   (FQ_DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk       (clk),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign dec_valid    = (count != '0);
  assign dec_instr    = dec_valid ? head.instr : '0;
  assign dec_pc       = dec_valid ? head.pc : '0;
  assign dec_pc_plus4 = dec_valid ? head.pc + DATA_WIDTH'(4) : '0;

  // PC and in-flight bookkeeping. On redirect every response still in
  // flight is stale; outstanding already includes the ones an earlier
  // redirect marked for dropping, so it alone (less the response arriving
  // now) is the new drop count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_aligned;
      resp_pc     <= redirect_aligned;
      outstanding <= outstanding - CW'(imem_rvalid);
      drop        <= outstanding - CW'(imem_rvalid);
    end else begin
      if (fire) fetch_pc <= fetch_pc + DATA_WIDTH'(4);
      if (push) resp_pc <= resp_pc + DATA_WIDTH'(4);
      outstanding <= outstanding + CW'(fire) - CW'(imem_rvalid);
      if (drop_now) drop <= drop - 1'b1;
    end
  end

  // A kept response must never find the queue full.
  assert property (@(posedge clk) disable iff (!rst)
    !(imem_rvalid && (drop == '0) && (count == CW'(FQ_DEPTH))));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table for the streaming
// start-up, then hand-written sequences for backpressure, redirect and reset.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst, redirect_valid, imem_gnt, imem_rvalid, dec_ready;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, dec_valid;
  logic [31:0] imem_addr, dec_instr, dec_pc, dec_pc_plus4;

  always #5 clk = ~clk;

  fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'hBFC00000), .FQ_DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_pc_plus4   (dec_pc_plus4)
  );

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct {
    logic rst, gnt, ready, req;
    logic [31:0] addr;
    logic dvalid;
    logic [31:0] dpc;
  } vec_t;

  pend_t       pend[$];
  vec_t        tbl[11];
  int          checks = 0, errors = 0, ncyc = 0, lat = 1, fires = 0, pops = 0;
  logic [31:0] exp_fa, exp_pc, first_pc, first_p4;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: called at a negedge with inputs set. Checks fetch addresses
  // and popped entries against the sequential-PC model, then advances the
  // memory model (fixed latency `lat`, in order).
  task automatic cycle();
    logic fire, popd;
    logic [31:0] addr_q;
    #1;
    fire   = imem_req & imem_gnt;
    popd   = dec_valid & dec_ready;
    addr_q = imem_addr;
    if (redirect_valid) chk("req_in_redirect", imem_req, 1'b0);
    if (fire === 1'b1) begin
      chk("fetch_addr", imem_addr, exp_fa);
      exp_fa = exp_fa + 32'd4;
      fires++;
    end
    if (popd === 1'b1) begin
      if (pops == 0) begin
        first_pc = dec_pc;
        first_p4 = dec_pc_plus4;
      end
      pops++;
      chk("dec_pc", dec_pc, exp_pc);
      chk("dec_instr", dec_instr, instr_of(exp_pc));
      chk("dec_pc_plus4", dec_pc_plus4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
    end
    if (redirect_valid) begin
      exp_fa = redirect_pc & ~32'd3;
      exp_pc = redirect_pc & ~32'd3;
    end
    if (!rst) begin
      exp_fa = RST_PC;
      exp_pc = RST_PC;
    end
    @(posedge clk);
    ncyc++;
    if (!rst) pend.delete();
    else if (fire === 1'b1) pend.push_back('{addr: addr_q, due: ncyc + lat});
    @(negedge clk);
    if (rst && pend.size() > 0 && pend[0].due <= ncyc + 1) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  endtask

  task automatic wait_first_pop(input string name, input logic [31:0] exp_first);
    pops = 0;
    for (int i = 0; i < 20 && pops == 0; i++) cycle();
    chk({name, "_got_pop"}, (pops > 0) ? 32'd1 : 32'd0, 32'd1);
    chk({name, "_first_pc"}, first_pc, exp_first);
  endtask

  initial begin
    // rst, gnt, ready | req, addr, dvalid, dpc   (latency 1)
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hBFC00000, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hBFC00000, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hBFC00004, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hBFC00008, 1'b1, 32'hBFC00000};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hBFC0000C, 1'b1, 32'hBFC00004};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hBFC00010, 1'b1, 32'hBFC00008};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hBFC00014, 1'b1, 32'hBFC0000C};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hBFC00018, 1'b1, 32'hBFC00010};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hBFC00018, 1'b1, 32'hBFC00014};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hBFC0001C, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hBFC00020, 1'b1, 32'hBFC00018};

    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_gnt = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = '0; dec_ready = 1'b1;
    exp_fa = RST_PC; exp_pc = RST_PC; first_pc = '0; first_p4 = '0;
    @(negedge clk);
    cycle();

    // Streaming start-up and a one-cycle grant bubble.
    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst; imem_gnt = tbl[i].gnt; dec_ready = tbl[i].ready;
      #1;
      chk($sformatf("v%0d_req", i), imem_req, tbl[i].req);
      chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("v%0d_dvalid", i), dec_valid, tbl[i].dvalid);
      chk($sformatf("v%0d_dpc", i), dec_pc, tbl[i].dpc);
      chk($sformatf("v%0d_dp4", i), dec_pc_plus4, tbl[i].dvalid ? tbl[i].dpc + 32'd4 : 32'd0);
      chk($sformatf("v%0d_instr", i), dec_instr, tbl[i].dvalid ? instr_of(tbl[i].dpc) : 32'd0);
      cycle();
    end

    // Backpressure: credits stop issue after four fetches.
    rst = 1'b0; imem_gnt = 1'b1; cycle();
    rst = 1'b1; dec_ready = 1'b0; lat = 1; fires = 0;
    repeat (10) cycle();
    chk("bp_fires", fires, 32'd4);
    #1;
    chk("bp_req_low", imem_req, 1'b0);
    chk("bp_head_pc", dec_pc, RST_PC);
    chk("bp_valid", dec_valid, 1'b1);
    dec_ready = 1'b1; pops = 0;
    repeat (4) cycle();
    chk("bp_pops", pops, 32'd4);
    chk("bp_first_pc", first_pc, RST_PC);

    // Latency 3, redirect with three fetches in flight.
    rst = 1'b0; cycle();
    rst = 1'b1; lat = 3;
    repeat (3) cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h00001002;
    cycle();
    redirect_valid = 1'b0;
    #1;
    chk("r3_req", imem_req, 1'b1);
    chk("r3_addr", imem_addr, 32'h00001000);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("r3_empty%0d", k), dec_valid, 1'b0);
      cycle();
    end
    wait_first_pop("r3", 32'h00001000);

    // Redirect coinciding with a response and a pop (latency 2 steady state).
    rst = 1'b0; cycle();
    rst = 1'b1; lat = 2;
    repeat (8) cycle();
    #1;
    chk("r4_head_valid", dec_valid, 1'b1);
    pops = 0;
    redirect_valid = 1'b1; redirect_pc = 32'h00002000;
    cycle();
    redirect_valid = 1'b0;
    chk("r4_pop_taken", pops, 32'd1);
    #1;
    chk("r4_empty", dec_valid, 1'b0);
    wait_first_pop("r4", 32'h00002000);
    repeat (4) cycle();

    // Redirect to the top word: fetch addresses wrap to zero.
    lat = 1;
    repeat (3) cycle();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFC;
    cycle();
    redirect_valid = 1'b0;
    #1;
    chk("wrap_addr0", imem_addr, 32'hFFFFFFFC);
    cycle();
    #1;
    chk("wrap_addr1", imem_addr, 32'h00000000);
    wait_first_pop("wrap", 32'hFFFFFFFC);
    chk("wrap_plus4", first_p4, 32'h00000000);
    repeat (3) cycle();

    // Reset mid-stream with the queue full.
    dec_ready = 1'b0;
    repeat (8) cycle();
    #1;
    chk("rs_full_valid", dec_valid, 1'b1);
    chk("rs_full_req", imem_req, 1'b0);
    rst = 1'b0;
    cycle();
    #1;
    chk("rs_req", imem_req, 1'b0);
    chk("rs_addr", imem_addr, RST_PC);
    chk("rs_valid", dec_valid, 1'b0);
    chk("rs_instr", dec_instr, 32'h0);
    chk("rs_pc", dec_pc, 32'h0);
    chk("rs_p4", dec_pc_plus4, 32'h0);
    rst = 1'b1; dec_ready = 1'b1;
    wait_first_pop("rs", RST_PC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
